// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, widths and reset pattern for the detector scheduler
package seq_det_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  typedef logic [PAT_W_DEF-1:0] pat_t;
  typedef logic [DATA_W_DEF-1:0] mask_t;
  localparam pat_t PAT_RESET_DEF = 4'b1101;
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: requester, pattern-config and response signals of the detector scheduler
interface seq_det_if import seq_det_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W = PAT_W_DEF
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic cfg_err;
  logic busy;
  logic rsp_valid;
  logic rsp_ready;
  logic [$clog2(N_REQ)-1:0] rsp_id;
  logic [$clog2(DATA_W+1)-1:0] rsp_count;
  logic [DATA_W-1:0] rsp_mask;
  modport master (
    output req_valid, req_data, cfg_we, cfg_pattern, rsp_ready,
    input req_ready, cfg_err, busy, rsp_valid, rsp_id, rsp_count, rsp_mask
  );
  modport slave (
    input req_valid, req_data, cfg_we, cfg_pattern, rsp_ready,
    output req_ready, cfg_err, busy, rsp_valid, rsp_id, rsp_count, rsp_mask
  );
endinterface

// File: rtl/seq_det_window.sv
// seq_det_window: serial shift window with clear and compare against a programmable pattern
module seq_det_window #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  logic [PAT_W-2:0] win_q, win_d;
  logic [PAT_W-1:0] shifted;
  // only the newest PAT_W-1 bits are stored; the incoming bit completes the compared window
  always_comb begin
    shifted = {win_q, bit_in};
    win_d = clr ? '0 : shift_en ? shifted[PAT_W-2:0] : win_q;
    hit = shift_en && shifted == pattern;
  end
  // window history register
  always_ff @(posedge clk or posedge reset)
    if (reset) win_q <= '0;
    else win_q <= win_d;
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin time-sharing of one serial pattern detector among byte requesters
module seq_det_scheduler import seq_det_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
  input logic       clk,
  input logic       reset,
  seq_det_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int KW = $clog2(DATA_W);
  localparam int CW = $clog2(DATA_W+1);
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, grant_id, idx;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [DATA_W-1:0] data_q, data_d, mask_q, mask_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] count_q, count_d;
  logic found, idle, accept, hit, bit_in;
  seq_det_window #(.PAT_W(PAT_W)) u_window (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .shift_en (state_q == SHIFT),
    .bit_in   (bit_in),
    .pattern  (pattern_q),
    .hit      (hit)
  );
  // round-robin search for the first valid requester at or after rr_ptr
  always_comb begin
    found = 1'b0;
    grant_id = '0;
    idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = IDW'((int'(rr_ptr_q) + j) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant_id = idx;
      end
    end
  end
  // FSM next state, job capture, match accumulation and pattern update
  always_comb begin
    idle = state_q == IDLE;
    accept = idle && found && !reset;
    bus.req_ready = accept ? N_REQ'(1) << grant_id : '0;
    bit_in = data_q[KW'(DATA_W-1) - k_q];
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    pattern_d = bus.cfg_we && idle ? bus.cfg_pattern : pattern_q;
    data_d = data_q;
    id_d = id_q;
    k_d = k_q;
    count_d = count_q;
    mask_d = mask_q;
    case (state_q)
      IDLE: if (accept) begin
        data_d = bus.req_data[grant_id*DATA_W +: DATA_W];
        id_d = grant_id;
        rr_ptr_d = IDW'((int'(grant_id) + 1) % N_REQ);
        k_d = '0;
        count_d = '0;
        mask_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        k_d = k_q + 1'b1;
        if (hit && int'(k_q) >= PAT_W-1) begin
          mask_d[k_q] = 1'b1;
          count_d = count_q + 1'b1;
        end
        if (k_q == KW'(DATA_W-1)) state_d = REPORT;
      end
      default: if (bus.rsp_ready) state_d = IDLE;
    endcase
  end
  assign bus.busy = !idle;
  assign bus.cfg_err = bus.cfg_we && !idle && !reset;
  assign bus.rsp_valid = state_q == REPORT;
  assign bus.rsp_id = id_q;
  assign bus.rsp_count = count_q;
  assign bus.rsp_mask = mask_q;
  // state and datapath registers; reset aborts any job in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      pattern_q <= PAT_RESET;
      data_q <= '0;
      id_q <= '0;
      k_q <= '0;
      count_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      pattern_q <= pattern_d;
      data_q <= data_d;
      id_q <= id_d;
      k_q <= k_d;
      count_q <= count_d;
      mask_q <= mask_d;
    end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: randomized self-checking bench against a behavioural detector model
module tb_seq_det_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  seq_det_if bif ();
  seq_det_scheduler dut (.clk(clk), .reset(reset), .bus(bif));
  int tests = 0;
  int fails = 0;
  int rr_m = 0;
  logic [3:0] pat_m = 4'b1101;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int arb(input logic [3:0] v, input int p);
    for (int j = 0; j < 4; j++)
      if (v[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  // window ending at shifted bit k covers data bits (7-k+3) down to (7-k)
  function automatic void ref_match(input logic [7:0] d, input logic [3:0] p, output int c, output logic [7:0] m);
    c = 0;
    m = '0;
    for (int k = 3; k < 8; k++)
      if (((d >> (7 - k)) & 8'h0F) == {4'b0, p}) begin
        m[k] = 1'b1;
        c++;
      end
  endfunction

  task automatic run_job(input logic [3:0] vld, input logic [31:0] dat, input int stall,
                         input bit cfg_acc, input logic [3:0] newpat, input bit cfg_mid);
    int id, lat, c;
    logic [7:0] m;
    logic [1:0] id_s;
    logic [3:0] cnt_s;
    logic [7:0] mask_s;
    id = arb(vld, rr_m);
    bif.req_valid = vld;
    bif.req_data = dat;
    if (cfg_acc) begin
      bif.cfg_we = 1'b1;
      bif.cfg_pattern = newpat;
      pat_m = newpat;
    end
    #1;
    tests++;
    if (bif.req_ready !== 4'(1 << id)) begin
      fails++;
      $display("FAIL grant: req_ready=%b expected %b", bif.req_ready, 4'(1 << id));
    end
    if (cfg_acc) begin
      tests++;
      if (bif.cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err_idle: got %b expected 0", bif.cfg_err);
      end
    end
    tick();
    bif.req_valid = '0;
    bif.cfg_we = 1'b0;
    rr_m = (id + 1) % 4;
    ref_match(dat[id*8 +: 8], pat_m, c, m);
    lat = 1;
    while (bif.rsp_valid !== 1'b1 && lat < 30) begin
      if (cfg_mid && lat == 3) begin
        bif.cfg_we = 1'b1;
        bif.cfg_pattern = ~pat_m;
        #1;
        tests++;
        if (bif.cfg_err !== 1'b1) begin
          fails++;
          $display("FAIL cfg_err_pulse: got %b expected 1", bif.cfg_err);
        end
      end
      tick();
      lat++;
      if (cfg_mid && lat == 4) begin
        bif.cfg_we = 1'b0;
        #1;
        tests++;
        if (bif.cfg_err !== 1'b0) begin
          fails++;
          $display("FAIL cfg_err_clear: got %b expected 0", bif.cfg_err);
        end
      end
    end
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL latency: rsp_valid after %0d edges expected 9", lat);
    end
    tests++;
    if (bif.rsp_id !== 2'(id) || bif.rsp_count !== 4'(c) || bif.rsp_mask !== m) begin
      fails++;
      $display("FAIL result: id=%0d count=%0d mask=%b expected id=%0d count=%0d mask=%b",
               bif.rsp_id, bif.rsp_count, bif.rsp_mask, id, c, m);
    end
    id_s = bif.rsp_id;
    cnt_s = bif.rsp_count;
    mask_s = bif.rsp_mask;
    for (int s = 0; s < stall; s++) begin
      bif.req_valid = 4'hF;
      tick();
      tests++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_id !== id_s || bif.rsp_count !== cnt_s ||
          bif.rsp_mask !== mask_s || bif.req_ready !== 4'b0) begin
        fails++;
        $display("FAIL stall: valid=%b id=%0d count=%0d mask=%b ready=%b expected 1/%0d/%0d/%b/0000",
                 bif.rsp_valid, bif.rsp_id, bif.rsp_count, bif.rsp_mask, bif.req_ready, id_s, cnt_s, mask_s);
      end
    end
    bif.req_valid = '0;
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    tests++;
    if (bif.busy !== 1'b0 || bif.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL release: busy=%b rsp_valid=%b expected 0/0", bif.busy, bif.rsp_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bif.req_valid = 4'hF;
    bif.req_data = '0;
    bif.cfg_we = 1'b1;
    bif.cfg_pattern = '0;
    bif.rsp_ready = 1'b0;
    repeat (2) tick();
    tests++;
    if (bif.busy !== 1'b0 || bif.rsp_valid !== 1'b0 || bif.rsp_id !== 2'd0 || bif.rsp_count !== 4'd0 ||
        bif.rsp_mask !== 8'd0 || bif.req_ready !== 4'd0 || bif.cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: busy=%b valid=%b id=%0d count=%0d mask=%b ready=%b err=%b expected all 0",
               bif.busy, bif.rsp_valid, bif.rsp_id, bif.rsp_count, bif.rsp_mask, bif.req_ready, bif.cfg_err);
    end
    bif.req_valid = '0;
    bif.cfg_we = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int order[$];
    int when[$];
    bif.req_valid = 4'hF;
    bif.req_data = $urandom;
    bif.rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      for (int i = 0; i < 4; i++)
        if (bif.req_ready === 4'(1 << i)) begin
          order.push_back(i);
          when.push_back(cyc);
        end
      tick();
    end
    bif.req_valid = '0;
    for (int w = 0; w < 20 && bif.busy === 1'b1; w++) tick();
    bif.rsp_ready = 1'b0;
    tests++;
    if (bif.busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%b expected 0", bif.busy);
    end
    tests++;
    if (order.size() != 5) begin
      fails++;
      $display("FAIL b2b_count: %0d grants expected 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      tests++;
      if (order[i] != i % 4) begin
        fails++;
        $display("FAIL b2b_order: grant %0d went to %0d expected %0d", i, order[i], i % 4);
      end
      if (i > 0) begin
        tests++;
        if (when[i] - when[i-1] != 10) begin
          fails++;
          $display("FAIL b2b_spacing: grant %0d after %0d cycles expected 10", i, when[i] - when[i-1]);
        end
      end
    end
    if (order.size() > 0) rr_m = (order[order.size()-1] + 1) % 4;
  endtask

  task automatic test_cfg_idle;
    bif.cfg_we = 1'b1;
    bif.cfg_pattern = 4'b1111;
    #1;
    tests++;
    if (bif.cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL cfg_idle_err: got %b expected 0", bif.cfg_err);
    end
    tick();
    bif.cfg_we = 1'b0;
    pat_m = 4'b1111;
    run_job(4'b0100, 32'h00FF_0000, 0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit seen;
    bif.req_valid = 4'b1000;
    bif.req_data = $urandom;
    #1;
    tick();
    bif.req_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    tests++;
    if (bif.busy !== 1'b0 || bif.rsp_valid !== 1'b0 || bif.rsp_id !== 2'd0 ||
        bif.rsp_count !== 4'd0 || bif.rsp_mask !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b valid=%b id=%0d count=%0d mask=%b expected all 0",
               bif.busy, bif.rsp_valid, bif.rsp_id, bif.rsp_count, bif.rsp_mask);
    end
    tick();
    reset = 1'b0;
    rr_m = 0;
    pat_m = 4'b1101;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bif.rsp_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_orphan: rsp_valid seen=1 expected 0");
    end
    run_job(4'hF, $urandom, 0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++)
      run_job(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2),
              $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 4) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    run_job(4'b0001, 32'h0000_00DA, 0, 1'b0, 4'b0, 1'b0);
    test_cfg_idle();
    run_job(4'b0010, $urandom, 5, 1'b0, 4'b0, 1'b0);
    run_job(4'b1000, 32'hF7F7_F7F7, 0, 1'b0, 4'b0, 1'b1);
    run_job(4'b0001, 32'hF7F7_F7F7, 0, 1'b0, 4'b0, 1'b0);
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
